// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encodings,
// opcodes, ALUOp / ALUControl codes and datapath mux-select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUSrcA / ALUSrcB / ResultSrc / ImmSrc select values
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU-control decoder: maps ALUOp/funct3/funct7b5 to a 3-bit
// ALU code, zero-extended to ALUCTRL_W.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           alu_op_i,
  input  logic [2:0]           funct3_i,
  input  logic                 op_b5_i,
  input  logic                 funct7b5_i,
  output logic [ALUCTRL_W-1:0] alu_control_o
);

  logic [2:0] code_s;

  // ALU code selection
  always_comb begin
    code_s = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: code_s = ALU_ADD;
      ALUOP_SUB: code_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // only R-type (op[5]=1) with bit 30 set is a subtract; addi never is
          3'b000:  code_s = (op_b5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  code_s = ALU_SLL;
          3'b010:  code_s = ALU_SLT;
          3'b110:  code_s = ALU_OR;
          3'b111:  code_s = ALU_AND;
          default: code_s = ALU_ADD;
        endcase
      end
      default: code_s = ALU_ADD;
    endcase
  end

  assign alu_control_o = ALUCTRL_W'(code_s);

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle RV32I datapath.
// Optional: define MC_CTRL_BNE_EN to accept bne (funct3=001) as a branch.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal_op,
  output logic [STATE_W-1:0]   dbg_state
);

  state_e     state_q, state_d;
  logic [1:0] alu_op_s;
  logic       pc_update_s, branch_s, ir_write_s, reg_write_s, mem_write_s;
  logic       illegal_s, adr_src_s, taken_s, br_legal_s;
  logic [1:0] result_src_s, src_a_s, src_b_s, imm_src_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch legality and taken condition from funct3
  always_comb begin
    br_legal_s = 1'b0;
    taken_s    = 1'b0;
    case (funct3)
      3'b000: begin
        br_legal_s = 1'b1;
        taken_s    = Zero;
      end
`ifdef MC_CTRL_BNE_EN
      3'b001: begin
        br_legal_s = 1'b1;
        taken_s    = ~Zero;
      end
`endif
      default: begin
        br_legal_s = 1'b0;
        taken_s    = 1'b0;
      end
    endcase
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    alu_op_s     = ALUOP_ADD;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    illegal_s    = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = RES_ALUOUT;
    src_a_s      = SRCA_PC;
    src_b_s      = SRCB_REG;
    case (state_q)
      S_FETCH: begin
        src_b_s      = SRCB_FOUR;
        result_src_s = RES_ALU;
        ir_write_s   = mem_ready;
        pc_update_s  = mem_ready;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_a_s = SRCA_OLDPC;
        src_b_s = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR: begin
            if (br_legal_s) begin
              state_d = S_BRANCH;
            end else begin
              state_d   = S_FETCH;
              illegal_s = 1'b1;
            end
          end
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        src_a_s = SRCA_REG;
        src_b_s = SRCB_IMM;
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        state_d   = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        src_a_s  = SRCA_REG;
        alu_op_s = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_EXECI: begin
        src_a_s  = SRCA_REG;
        src_b_s  = SRCB_IMM;
        alu_op_s = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_s  = SRCA_REG;
        alu_op_s = ALUOP_SUB;
        branch_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        src_a_s     = SRCA_OLDPC;
        src_b_s     = SRCB_FOUR;
        pc_update_s = 1'b1;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode directly
  always_comb begin
    imm_src_s = IMM_I;
    case (op)
      OP_I, OP_LW: imm_src_s = IMM_I;
      OP_SW:       imm_src_s = IMM_S;
      OP_BR:       imm_src_s = IMM_B;
      OP_JAL:      imm_src_s = IMM_J;
      default:     imm_src_s = IMM_I;
    endcase
  end

  mc_alu_decoder #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_dec (
    .alu_op_i     (alu_op_s),
    .funct3_i     (funct3),
    .op_b5_i      (op[5]),
    .funct7b5_i   (funct7b5),
    .alu_control_o(ALUControl)
  );

  // Write enables are suppressed while reset is held so no write escapes an abort
  assign PCWrite    = ~reset & (pc_update_s | (branch_s & taken_s));
  assign IRWrite    = ~reset & ir_write_s;
  assign RegWrite   = ~reset & reg_write_s;
  assign MemWrite   = ~reset & mem_write_s;
  assign illegal_op = ~reset & illegal_s;
  assign AdrSrc     = adr_src_s;
  assign ResultSrc  = result_src_s;
  assign ALUSrcA    = src_a_s;
  assign ALUSrcB    = src_b_s;
  assign ImmSrc     = imm_src_s;
  assign dbg_state  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, hand-written
// corner sequences and randomized instructions against a per-instruction model.
module tb_multicycle_controller;

  localparam int AW = 3;
  localparam int SW = 4;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_ILL = 7'b1110011;

  logic          clk = 1'b0;
  logic          reset, funct7b5, Zero, mem_ready;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [AW-1:0] ALUControl;
  logic [SW-1:0] dbg_state;

  multicycle_controller #(.ALUCTRL_W(AW), .STATE_W(SW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int len; int regw; int memw; int pcw; int irw; int ill; int alu;
  } res_t;

  typedef struct {
    logic [6:0] o; logic [2:0] f3; logic f7; logic z; int mw; res_t e;
  } vec_t;

  int seq[$];
  int regw_rs;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t mk(input int len, input int regw, input int memw,
                              input int pcw, input int ill, input int alu);
    res_t r;
    r.len = len; r.regw = regw; r.memw = memw; r.pcw = pcw;
    r.irw = 1; r.ill = ill; r.alu = alu;
    return r;
  endfunction

  function automatic int alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o[5] && f7) ? 1 : 0;
      3'd1:    return 4;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return 0;
    endcase
  endfunction

  // Whole-instruction expectations: cycle count and number of cycles each enable is high
  function automatic res_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input int fw, input int mw);
    bit legal;
    bit tk;
    legal = (f3 == 3'd0);
    tk    = z;
`ifdef MC_CTRL_BNE_EN
    if (f3 == 3'd1) begin
      legal = 1'b1;
      tk    = !z;
    end
`endif
    if (o == T_LW)                return mk(5 + fw + mw, 1, 0, 1, 0, -1);
    if (o == T_SW)                return mk(4 + fw + mw, 0, 1 + mw, 1, 0, -1);
    if (o == T_R || o == T_I)     return mk(4 + fw, 1, 0, 1, 0, alu_ref(o, f3, f7));
    if (o == T_JAL)               return mk(4 + fw, 1, 0, 2, 0, -1);
    if (o == T_BR && legal)       return mk(3 + fw, 0, 0, 1 + int'(tk), 0, -1);
    return mk(2 + fw, 0, 0, 1, 1, -1);
  endfunction

  // Runs one instruction from FETCH; fw fetch-wait and mw memory-wait cycles
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw, output res_t r);
    bit left;
    bit done;
    bit ismem;
    left  = 1'b0;
    done  = 1'b0;
    ismem = (o == T_LW) || (o == T_SW);
    r = mk(-1, 0, 0, 0, 0, -1);
    r.irw = 0;
    seq.delete();
    regw_rs  = -1;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (k < fw)                                       mem_ready = 1'b0;
      else if (k == fw)                                 mem_ready = 1'b1;
      else if (ismem && k >= fw + 3 && k < fw + 3 + mw) mem_ready = 1'b0;
      else if (ismem && k >= fw + 3)                    mem_ready = 1'b1;
      else                                              mem_ready = 1'($urandom_range(0, 1));
      #1;
      seq.push_back(int'(dbg_state));
      r.regw += int'(RegWrite);
      r.memw += int'(MemWrite);
      r.pcw  += int'(PCWrite);
      r.irw  += int'(IRWrite);
      r.ill  += int'(illegal_op);
      if (RegWrite) regw_rs = int'(ResultSrc);
      if (k == fw + 2) r.alu = int'(ALUControl);
      @(posedge clk);
      #1;
      if (dbg_state != '0) left = 1'b1;
      if (left && dbg_state == '0) begin
        r.len = k + 1;
        done  = 1'b1;
      end
    end
  endtask

  task automatic compare(input string nm, input res_t r, input res_t e);
    chk({nm, ".len"},  r.len,  e.len);
    chk({nm, ".regw"}, r.regw, e.regw);
    chk({nm, ".memw"}, r.memw, e.memw);
    chk({nm, ".pcw"},  r.pcw,  e.pcw);
    chk({nm, ".irw"},  r.irw,  e.irw);
    chk({nm, ".ill"},  r.ill,  e.ill);
    if (e.alu >= 0) chk({nm, ".alu"}, r.alu, e.alu);
  endtask

  task automatic check_seq(input string nm, input int exp[$]);
    chk({nm, ".nstates"}, seq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s.state%0d", nm, i), (i < seq.size()) ? seq[i] : -1, exp[i]);
    end
  endtask

  task automatic realign();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    res_t r;
    int   exp_seq[$];

    reset = 1'b1; mem_ready = 1'b1; op = T_R; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    #2;
    chk("rst.state",     int'(dbg_state), 0);
    chk("rst.PCWrite",   int'(PCWrite),   0);
    chk("rst.IRWrite",   int'(IRWrite),   0);
    chk("rst.MemWrite",  int'(MemWrite),  0);
    chk("rst.ALUSrcB",   int'(ALUSrcB),   2);
    chk("rst.ResultSrc", int'(ResultSrc), 2);
    realign();

    tbl.push_back('{T_R,   3'd0, 1'b0, 1'b0, 0, mk(4, 1, 0, 1, 0, 0)});
    tbl.push_back('{T_R,   3'd0, 1'b1, 1'b0, 0, mk(4, 1, 0, 1, 0, 1)});
    tbl.push_back('{T_I,   3'd0, 1'b1, 1'b0, 0, mk(4, 1, 0, 1, 0, 0)});
    tbl.push_back('{T_I,   3'd1, 1'b0, 1'b0, 0, mk(4, 1, 0, 1, 0, 4)});
    tbl.push_back('{T_R,   3'd2, 1'b0, 1'b0, 0, mk(4, 1, 0, 1, 0, 5)});
    tbl.push_back('{T_R,   3'd6, 1'b0, 1'b0, 0, mk(4, 1, 0, 1, 0, 3)});
    tbl.push_back('{T_I,   3'd7, 1'b0, 1'b0, 0, mk(4, 1, 0, 1, 0, 2)});
    tbl.push_back('{T_R,   3'd4, 1'b0, 1'b0, 0, mk(4, 1, 0, 1, 0, 0)});
    tbl.push_back('{T_LW,  3'd2, 1'b0, 1'b0, 0, mk(5, 1, 0, 1, 0, -1)});
    tbl.push_back('{T_SW,  3'd2, 1'b0, 1'b0, 1, mk(5, 0, 2, 1, 0, -1)});
    tbl.push_back('{T_BR,  3'd0, 1'b0, 1'b1, 0, mk(3, 0, 0, 2, 0, -1)});
    tbl.push_back('{T_BR,  3'd0, 1'b0, 1'b0, 0, mk(3, 0, 0, 1, 0, -1)});
    tbl.push_back('{T_JAL, 3'd0, 1'b0, 1'b0, 0, mk(4, 1, 0, 2, 0, -1)});
    tbl.push_back('{T_ILL, 3'd0, 1'b0, 1'b0, 0, mk(2, 0, 0, 1, 1, -1)});
`ifdef MC_CTRL_BNE_EN
    tbl.push_back('{T_BR,  3'd1, 1'b0, 1'b0, 0, mk(3, 0, 0, 2, 0, -1)});
`else
    tbl.push_back('{T_BR,  3'd1, 1'b0, 1'b0, 0, mk(2, 0, 0, 1, 1, -1)});
`endif
    tbl.push_back('{T_BR,  3'd4, 1'b0, 1'b1, 0, mk(2, 0, 0, 1, 1, -1)});

    foreach (tbl[i]) begin
      run_instr(tbl[i].o, tbl[i].f3, tbl[i].f7, tbl[i].z, 0, tbl[i].mw, r);
      compare($sformatf("vec%0d", i), r, tbl[i].e);
    end

    // add: states 0,1,6,8 and write-back from the ALU result
    run_instr(T_R, 3'd0, 1'b0, 1'b0, 0, 0, r);
    exp_seq = '{0, 1, 6, 8};
    check_seq("add", exp_seq);
    chk("add.rsrc", regw_rs, 0);

    // lw stalled two cycles in MEMREAD
    run_instr(T_LW, 3'd2, 1'b0, 1'b0, 0, 2, r);
    exp_seq = '{0, 1, 2, 3, 3, 3, 4};
    check_seq("lw_wait", exp_seq);
    chk("lw_wait.regw", r.regw, 1);
    chk("lw_wait.rsrc", regw_rs, 1);

    // reset landing in MEMWRITE kills the write at once
    op = T_SW; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("rstmw.fetch_ir", int'(IRWrite), 1);
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("rstmw.state", int'(dbg_state), 5);
    chk("rstmw.memw_pre", int'(MemWrite), 1);
    @(negedge clk); mem_ready = 1'b1; reset = 1'b1; #1;
    chk("rstmw.memw_rst", int'(MemWrite), 0);
    chk("rstmw.state_rst", int'(dbg_state), 0);
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
    chk("rstmw.state_rel", int'(dbg_state), 0);
    chk("rstmw.irw_rel", int'(IRWrite), 1);
    chk("rstmw.pcw_rel", int'(PCWrite), 1);
    chk("rstmw.memw_rel", int'(MemWrite), 0);
    @(posedge clk); #1;
    chk("rstmw.decode", int'(dbg_state), 1);
    realign();

    for (int n = 0; n < 80; n++) begin
      logic [6:0] o;
      logic [2:0] f3;
      logic       f7, z;
      int         fw, mw, pick;
      pick = $urandom_range(0, 6);
      case (pick)
        0: o = T_LW;
        1: o = T_SW;
        2: o = T_R;
        3: o = T_I;
        4: o = T_BR;
        5: o = T_JAL;
        default: begin
          o = 7'($urandom);
          if (o == T_LW || o == T_SW || o == T_R || o == T_I || o == T_BR || o == T_JAL)
            o = T_ILL;
        end
      endcase
      f3 = 3'($urandom);
      if (o == T_BR && $urandom_range(0, 1) == 1) f3 = 3'($urandom_range(0, 1));
      f7 = 1'($urandom);
      z  = 1'($urandom);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      run_instr(o, f3, f7, z, fw, mw, r);
      compare($sformatf("rnd%0d", n), r, model(o, f3, f7, z, fw, mw));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
